// File: rtl/timer_wb_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : timer_wb_arb_pkg                                             |
// | Description : Shared types and constants for the timer Wishbone arbiter.   |
// |               MAX_MASTERS bounds NUM_MASTERS; IDX_W is the width of a      |
// |               master index (grant index, rr pointer, timeout_id_o).        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package timer_wb_arb_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int IDX_W       = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/timer_wb_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : timer_wb_rr_pick                                             |
// | Description : Combinational round-robin picker. Finds the first set bit   |
// |               of req searching upward from ptr+1, wrapping at NUM_MASTERS.|
// | Ports       : req [NUM_MASTERS] request vector                             |
// |               ptr [IDX_W]       index of the last granted master           |
// |               gnt [NUM_MASTERS] one-hot winner (0 when no request)         |
// |               idx [IDX_W]       index of the winner                        |
// |               vld               at least one request present               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module timer_wb_rr_pick
  import timer_wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       idx,
  output logic                   vld
);

  logic [IDX_W:0]          w_start;
  logic [NUM_MASTERS-1:0]  w_mask;
  logic [2*NUM_MASTERS-1:0] w_dbl;

  // The low copy of req only keeps requesters at or above ptr+1; the high
  // copy is unmasked and supplies the wrapped-around candidates. The lowest
  // set bit of the doubled vector is therefore the round-robin winner.
  always_comb begin
    w_start = {1'b0, ptr} + {{IDX_W{1'b0}}, 1'b1};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_mask[i] = ((IDX_W+1)'(i) >= w_start);
    end
    w_dbl = {req, req & w_mask};

    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int j = 2*NUM_MASTERS-1; j >= 0; j--) begin
      if (w_dbl[j]) begin
        vld                   = 1'b1;
        idx                   = IDX_W'(j % NUM_MASTERS);
        gnt                   = '0;
        gnt[j % NUM_MASTERS]  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/timer_wb_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : timer_wb_arb                                                 |
// | Description : Round-robin Wishbone B4 arbiter sharing one timer slave     |
// |               between NUM_MASTERS masters, with a per-beat ACK watchdog.  |
// |               TIMEOUT_CYC = 0 disables the watchdog; otherwise it must    |
// |               satisfy TIMEOUT_CYC < 2**TO_W.                               |
// | Ports       : wb_clk_i / wb_rst_i    clock, async active-high reset       |
// |               m_*_i                  packed master requests (slice i)     |
// |               m_dat_o                slave read data, broadcast           |
// |               m_ack_o / m_err_o      per-master responses                 |
// |               s_*_o / s_*_i          slave side                           |
// |               gnt_o                  one-hot registered grant             |
// |               timeout_o              1-cycle pulse after watchdog expiry  |
// |               timeout_id_o           master index of the last expiry      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module timer_wb_arb
  import timer_wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT_CYC = 16,
  parameter int TO_W        = 8
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_MASTERS*32-1:0] m_adr_i,
  input  logic [NUM_MASTERS*32-1:0] m_dat_i,
  input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  output logic [31:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_we_o,
  output logic                      s_stb_o,
  output logic                      s_cyc_o,
  input  logic [31:0]               s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  output logic [NUM_MASTERS-1:0]    gnt_o,
  output logic                      timeout_o,
  output logic [2:0]                timeout_id_o
);

  localparam bit              c_wd_en   = (TIMEOUT_CYC > 0);
  localparam logic [TO_W-1:0] c_to_last = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] c_ptr_rst = IDX_W'(NUM_MASTERS - 1);

  arb_state_e             r_state;
  logic [NUM_MASTERS-1:0] r_gnt;
  logic [IDX_W-1:0]       r_gnt_idx;
  logic [IDX_W-1:0]       r_ptr;
  logic [TO_W-1:0]        r_to_cnt;
  logic                   r_to_block;
  logic                   r_timeout;
  logic [IDX_W-1:0]       r_timeout_id;

  logic [NUM_MASTERS-1:0] w_pick_gnt;
  logic [IDX_W-1:0]       w_pick_idx;
  logic                   w_pick_vld;

  logic [31:0]            w_adr;
  logic [31:0]            w_dat;
  logic [3:0]             w_sel;
  logic                   w_we;
  logic                   w_stb;
  logic                   w_cyc;
  logic                   w_stb_gated;
  logic                   w_resp;
  logic                   w_expire;
  logic                   w_ack_fwd;
  logic                   w_err_fwd;

  timer_wb_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_pick (
    .req (m_cyc_i),
    .ptr (r_ptr),
    .gnt (w_pick_gnt),
    .idx (w_pick_idx),
    .vld (w_pick_vld)
  );

  // One-hot mux driven by the registered grant. With r_gnt all-zero (IDLE or
  // reset) every slave-side signal is 0, so reset drops STB/CYC immediately.
  always_comb begin
    w_adr = '0;
    w_dat = '0;
    w_sel = '0;
    w_we  = 1'b0;
    w_stb = 1'b0;
    w_cyc = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_gnt[i]) begin
        w_adr = m_adr_i[32*i +: 32];
        w_dat = m_dat_i[32*i +: 32];
        w_sel = m_sel_i[4*i +: 4];
        w_we  = m_we_i[i];
        w_stb = m_stb_i[i];
        w_cyc = m_cyc_i[i];
      end
    end
  end

  assign w_stb_gated = w_stb & ~r_to_block;
  assign w_resp      = s_ack_i | s_err_i;
  // A response arriving in the expiry cycle wins over the timeout.
  assign w_expire    = c_wd_en & w_stb_gated & ~w_resp & (r_to_cnt == c_to_last);
  // After a timeout, a late response for the abandoned beat is swallowed.
  assign w_ack_fwd   = s_ack_i & ~r_to_block;
  assign w_err_fwd   = (s_err_i & ~r_to_block) | w_expire;

  assign s_adr_o      = w_adr;
  assign s_dat_o      = w_dat;
  assign s_sel_o      = w_sel;
  assign s_we_o       = w_we;
  assign s_cyc_o      = w_cyc;
  assign s_stb_o      = w_stb_gated;
  assign m_dat_o      = s_dat_i;
  assign m_ack_o      = r_gnt & {NUM_MASTERS{w_ack_fwd}};
  assign m_err_o      = r_gnt & {NUM_MASTERS{w_err_fwd}};
  assign gnt_o        = r_gnt;
  assign timeout_o    = r_timeout;
  assign timeout_id_o = r_timeout_id;

  // Arbitration FSM: grant is registered, held until the owner drops CYC,
  // and always followed by one IDLE cycle before the next grant.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_ptr     <= c_ptr_rst;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_vld) begin
            r_state   <= GRANT;
            r_gnt     <= w_pick_gnt;
            r_gnt_idx <= w_pick_idx;
            r_ptr     <= w_pick_idx;
          end
        end
        GRANT: begin
          if (!w_cyc) begin
            r_state <= IDLE;
            r_gnt   <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  // Watchdog: counts unanswered strobe cycles of the current beat.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_to_cnt     <= '0;
      r_to_block   <= 1'b0;
      r_timeout    <= 1'b0;
      r_timeout_id <= '0;
    end else begin
      r_timeout <= 1'b0;
      if (r_state != GRANT || !w_cyc) begin
        r_to_cnt   <= '0;
        r_to_block <= 1'b0;
      end else if (w_expire) begin
        r_to_cnt     <= '0;
        r_to_block   <= 1'b1;
        r_timeout    <= 1'b1;
        r_timeout_id <= r_gnt_idx;
      end else if (r_to_block) begin
        r_to_cnt <= '0;
        // The abandoned beat ends once the master withdraws its strobe.
        if (!w_stb) begin
          r_to_block <= 1'b0;
        end
      end else if (c_wd_en && w_stb && !w_resp) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_wb_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_timer_wb_arb                                              |
// | Description : Directed self-checking bench for timer_wb_arb with a        |
// |               registered-ACK slave model of programmable latency.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_timer_wb_arb;

  localparam int          NM   = 2;
  localparam logic [31:0] DKEY = 32'hC0DE_0000;

  logic               wb_clk_i = 1'b0;
  logic               wb_rst_i = 1'b1;
  logic [NM*32-1:0]   m_adr_i  = '0;
  logic [NM*32-1:0]   m_dat_i  = '0;
  logic [NM*4-1:0]    m_sel_i  = '0;
  logic [NM-1:0]      m_we_i   = '0;
  logic [NM-1:0]      m_stb_i  = '0;
  logic [NM-1:0]      m_cyc_i  = '0;
  logic [31:0]        m_dat_o;
  logic [NM-1:0]      m_ack_o;
  logic [NM-1:0]      m_err_o;
  logic [31:0]        s_adr_o;
  logic [31:0]        s_dat_o;
  logic [3:0]         s_sel_o;
  logic               s_we_o;
  logic               s_stb_o;
  logic               s_cyc_o;
  logic [31:0]        s_dat_i;
  logic               s_ack_i;
  logic               s_err_i;
  logic [NM-1:0]      gnt_o;
  logic               timeout_o;
  logic [2:0]         timeout_id_o;

  logic s_ack_r;
  logic force_ack = 1'b0;
  int   slv_lat   = 1;
  int   wait_cnt;
  int   checks    = 0;
  int   failures  = 0;

  // Expected grant per cycle while both masters keep re-requesting.
  logic [1:0] exp_alt [12] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0,
                               2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0};

  timer_wb_arb #(
    .NUM_MASTERS (NM),
    .TIMEOUT_CYC (16),
    .TO_W        (8)
  ) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .m_adr_i      (m_adr_i),
    .m_dat_i      (m_dat_i),
    .m_sel_i      (m_sel_i),
    .m_we_i       (m_we_i),
    .m_stb_i      (m_stb_i),
    .m_cyc_i      (m_cyc_i),
    .m_dat_o      (m_dat_o),
    .m_ack_o      (m_ack_o),
    .m_err_o      (m_err_o),
    .s_adr_o      (s_adr_o),
    .s_dat_o      (s_dat_o),
    .s_sel_o      (s_sel_o),
    .s_we_o       (s_we_o),
    .s_stb_o      (s_stb_o),
    .s_cyc_o      (s_cyc_o),
    .s_dat_i      (s_dat_i),
    .s_ack_i      (s_ack_i),
    .s_err_i      (s_err_i),
    .gnt_o        (gnt_o),
    .timeout_o    (timeout_o),
    .timeout_id_o (timeout_id_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Slave: ACK rises slv_lat cycles after the strobe is first seen
  // (slv_lat = 0 never acknowledges); force_ack injects a stray ACK.
  assign s_ack_i = s_ack_r | force_ack;
  assign s_err_i = 1'b0;
  assign s_dat_i = s_adr_o ^ DKEY;

  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s_ack_r  <= 1'b0;
      wait_cnt <= 0;
    end else if (s_stb_o && s_cyc_o && !s_ack_r) begin
      if (slv_lat != 0 && wait_cnt + 1 == slv_lat) begin
        s_ack_r  <= 1'b1;
        wait_cnt <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      s_ack_r <= 1'b0;
      if (!s_stb_o) wait_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input int i, input bit cyc, input bit stb, input bit we,
                       input logic [31:0] adr, input logic [31:0] dat);
    m_cyc_i[i]          = cyc;
    m_stb_i[i]          = stb;
    m_we_i[i]           = we;
    m_adr_i[32*i +: 32] = adr;
    m_dat_i[32*i +: 32] = dat;
    m_sel_i[4*i +: 4]   = 4'hF;
  endtask

  task automatic nxt();
    @(posedge wb_clk_i);
    #2;
  endtask

  initial begin
    #1000000;
    $display("FAIL tb_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state
    #12;
    check("rst_gnt", gnt_o, 0);
    check("rst_s_cyc", s_cyc_o, 0);
    check("rst_ack", m_ack_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_timeout_id", timeout_id_o, 0);
    wb_rst_i = 1'b0;
    nxt();

    // Single master 0 write
    drive(0, 1, 1, 1, 32'h0, 32'h3);
    #1;
    check("t1_idle_gnt", gnt_o, 0);
    check("t1_idle_stb", s_stb_o, 0);
    nxt();
    check("t1_gnt", gnt_o, 2'b01);
    check("t1_s_stb", s_stb_o, 1);
    check("t1_s_dat", s_dat_o, 32'h3);
    check("t1_s_we", s_we_o, 1);
    check("t1_no_ack", m_ack_o, 0);
    nxt();
    check("t1_ack", m_ack_o, 2'b01);
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    #1;
    check("t1_s_cyc_drop", s_cyc_o, 0);
    nxt();
    check("t1_release", gnt_o, 0);

    // Both masters requesting: round-robin alternation, one idle between
    drive(0, 1, 1, 0, 32'h4, 32'h0);
    drive(1, 1, 1, 0, 32'h8, 32'h0);
    for (int k = 0; k < 12; k++) begin
      nxt();
      check($sformatf("t2_gnt%0d", k), gnt_o, exp_alt[k]);
      for (int i = 0; i < NM; i++) begin
        if (m_ack_o[i]) drive(i, 0, 0, 0, 32'h0, 32'h0);
        else if (!m_cyc_i[i]) drive(i, 1, 1, 0, 32'h4 * (i + 1), 32'h0);
      end
    end
    m_cyc_i = '0;
    m_stb_i = '0;
    nxt();
    nxt();

    // Master 1 holds CYC over three reads; master 0 must wait
    drive(1, 1, 1, 0, 32'h10, 32'h0);
    drive(0, 1, 1, 0, 32'h40, 32'h0);
    nxt();
    check("t3_gnt_m1", gnt_o, 2'b10);
    check("t3_adr0", s_adr_o, 32'h10);
    for (int b = 0; b < 3; b++) begin
      nxt();
      check($sformatf("t3_ack%0d", b), m_ack_o, 2'b10);
      check($sformatf("t3_dat%0d", b), m_dat_o, (32'h10 + 32'(4 * b)) ^ DKEY);
      check($sformatf("t3_hold%0d", b), gnt_o, 2'b10);
      if (b < 2) begin
        drive(1, 1, 1, 0, 32'h10 + 32'(4 * (b + 1)), 32'h0);
        nxt();
        check($sformatf("t3_wait%0d", b), m_ack_o, 0);
      end else begin
        drive(1, 0, 0, 0, 32'h0, 32'h0);
      end
    end
    nxt();
    check("t3_idle", gnt_o, 0);
    nxt();
    check("t3_gnt_m0", gnt_o, 2'b01);
    nxt();
    check("t3_m0_ack", m_ack_o, 2'b01);
    check("t3_m0_dat", m_dat_o, 32'h40 ^ DKEY);
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    nxt();

    // Slave never answers: watchdog expires on the 16th strobe cycle
    slv_lat = 0;
    drive(1, 1, 1, 1, 32'h20, 32'h55);
    nxt();
    check("t4_gnt", gnt_o, 2'b10);
    repeat (14) nxt();
    check("t4_no_err_c15", m_err_o, 0);
    nxt();
    check("t4_err_c16", m_err_o, 2'b10);
    nxt();
    check("t4_timeout", timeout_o, 1);
    check("t4_timeout_id", timeout_id_o, 1);
    check("t4_stb_blocked", s_stb_o, 0);
    check("t4_err_once", m_err_o, 0);
    force_ack = 1'b1;
    #1;
    check("t4_late_ack_masked", m_ack_o, 0);
    nxt();
    check("t4_timeout_pulse", timeout_o, 0);
    check("t4_timeout_id_hold", timeout_id_o, 1);
    force_ack = 1'b0;
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    nxt();

    // Slave ACK exactly on the 16th strobe cycle: ACK wins
    slv_lat = 15;
    drive(0, 1, 1, 0, 32'h24, 32'h0);
    nxt();
    check("t5_gnt", gnt_o, 2'b01);
    repeat (14) nxt();
    check("t5_no_ack_c15", m_ack_o, 0);
    nxt();
    check("t5_ack_c16", m_ack_o, 2'b01);
    check("t5_no_err", m_err_o, 0);
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    nxt();
    check("t5_no_timeout", timeout_o, 0);
    check("t5_id_kept", timeout_id_o, 1);

    // Reset in the middle of a granted, strobing beat
    slv_lat = 0;
    drive(0, 1, 1, 0, 32'h28, 32'h0);
    nxt();
    check("t6_gnt_pre", gnt_o, 2'b01);
    nxt();
    #1;
    wb_rst_i = 1'b1;
    #1;
    check("t6_rst_gnt", gnt_o, 0);
    check("t6_rst_cyc", s_cyc_o, 0);
    check("t6_rst_stb", s_stb_o, 0);
    check("t6_rst_id", timeout_id_o, 0);
    drive(1, 1, 1, 0, 32'h2C, 32'h0);
    nxt();
    check("t6_in_rst", gnt_o, 0);
    wb_rst_i = 1'b0;
    nxt();
    check("t6_m0_first", gnt_o, 2'b01);
    m_cyc_i = '0;
    m_stb_i = '0;
    nxt();
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
